// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported, fixed-latency memory between the instruction
//   fetch requester (IF) and the data access requester (MEM stage). Each
//   access is held on the memory pins for LATENCY cycles. A down-counter
//   tracks the access, and the arbiter always returns to IDLE for one
//   turnaround cycle between accesses. Data accesses win over fetches
//   because the MEM-stage instruction is the older one.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-low reset
//   if_req/if_addr  : fetch request and address (held until done or flush)
//   if_flush        : cancels the outstanding fetch (branch redirect)
//   if_rdata/if_done: fetched word, valid during the one-cycle done pulse
//   if_stall        : fetch stage must hold
//   dm_rd/dm_wr     : data read/write request (held until dm_done)
//   dm_addr/dm_wdata: data address and write data
//   dm_rdata/dm_done: read data, valid during the one-cycle done pulse
//   dm_err          : misaligned data access, pulses together with dm_done
//   dm_stall        : MEM stage must hold
//   mem_*           : memory interface (enable, write, address, data)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_err,
  output logic          dm_stall,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, ERR_D} state_e;

  // The counter is loaded with LATENCY-1 so it reaches zero in the final
  // cycle of the access.
  localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] h_addr_q, h_addr_d;
  logic [DW-1:0] h_wdata_q, h_wdata_d;
  logic          h_wr_q, h_wr_d;
  logic          kill_q, kill_d;

  logic dmAny;
  logic busy;
  logic lastCycle;

  assign dmAny     = dm_rd | dm_wr;
  assign busy      = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign lastCycle = busy && (cnt_q == 4'd0);

  // State register: FSM state, countdown and holding registers. Reset is
  // asynchronous so the memory enable drops without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      h_addr_q  <= '0;
      h_wdata_q <= '0;
      h_wr_q    <= 1'b0;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      h_addr_q  <= h_addr_d;
      h_wdata_q <= h_wdata_d;
      h_wr_q    <= h_wr_d;
      kill_q    <= kill_d;
    end
  end

  // Next-state logic: one arbitration decision per IDLE cycle, data first.
  // A request with both rd and wr set is captured as a write. Request
  // inputs are only looked at in IDLE; during an access the holding
  // registers drive the memory.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    h_addr_d  = h_addr_q;
    h_wdata_d = h_wdata_q;
    h_wr_d    = h_wr_q;
    kill_d    = kill_q;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (dmAny) begin
          if (dm_addr[0]) begin
            state_d = ERR_D;
          end else begin
            state_d   = BUSY_D;
            cnt_d     = CntLoad;
            h_addr_d  = dm_addr;
            h_wdata_d = dm_wdata;
            h_wr_d    = dm_wr;
          end
        end else if (if_req && !if_flush) begin
          state_d  = BUSY_I;
          cnt_d    = CntLoad;
          h_addr_d = if_addr;
          h_wr_d   = 1'b0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          // A flushed fetch still runs to completion on the memory, but
          // its result must not be delivered.
          if ((state_q == BUSY_I) && if_flush) begin
            kill_d = 1'b1;
          end
        end
      end
      ERR_D:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: memory pins come straight from the holding registers while
  // busy and are zero otherwise. Completion pulses fire in the final cycle.
  always_comb begin
    mem_en    = busy;
    mem_wr    = busy & h_wr_q;
    mem_addr  = busy ? h_addr_q : '0;
    mem_wdata = busy ? h_wdata_q : '0;
    dm_done   = 1'b0;
    dm_err    = 1'b0;
    dm_rdata  = '0;
    if_done   = 1'b0;
    if_rdata  = '0;
    if (state_q == ERR_D) begin
      dm_done = 1'b1;
      dm_err  = 1'b1;
    end
    if (lastCycle && (state_q == BUSY_D)) begin
      dm_done = 1'b1;
      if (!h_wr_q) begin
        dm_rdata = mem_rdata;
      end
    end
    if (lastCycle && (state_q == BUSY_I) && !kill_q && !if_flush) begin
      if_done  = 1'b1;
      if_rdata = mem_rdata;
    end
  end

  assign dm_stall = dmAny & ~dm_done;
  assign if_stall = if_req & ~if_done & ~if_flush;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. A transaction-level model
//   (owner of the memory plus the age of the running access) predicts every
//   output on every cycle. Directed sequences with literal expectations pin
//   that model, and randomized requesters then exercise it. A second
//   instance built with LATENCY=1 covers back-to-back reads.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int LAT = 4;
  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;
  localparam int OWN_ERR  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifReq, ifFlush, dmRd, dmWr;
  logic [15:0] ifAddr, dmAddr, dmWdata, memRdata;
  logic [15:0] ifRdata, dmRdata, memAddr, memWdata;
  logic        ifDone, ifStall, dmDone, dmErr, dmStall, memEn, memWr;

  logic        l1Rd;
  logic [15:0] l1Addr, l1Mrd;
  logic [15:0] l1IfRdata, l1DmRdata, l1MemAddr, l1MemWdata;
  logic        l1IfDone, l1IfStall, l1DmDone, l1DmErr, l1DmStall, l1MemEn, l1MemWr;

  int total = 0;
  int bad   = 0;

  // Model state: who owns the memory, how many cycles of the access have
  // elapsed, the captured request and whether the fetch was cancelled.
  int          mOwner = OWN_NONE;
  int          mAge   = 0;
  logic [15:0] mAddr  = '0;
  logic [15:0] mWdata = '0;
  logic        mWr    = 1'b0;
  logic        mKill  = 1'b0;

  mem_port_arbiter #(.LATENCY(LAT), .AW(16), .DW(16)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(ifReq), .if_addr(ifAddr), .if_flush(ifFlush),
    .if_rdata(ifRdata), .if_done(ifDone), .if_stall(ifStall),
    .dm_rd(dmRd), .dm_wr(dmWr), .dm_addr(dmAddr), .dm_wdata(dmWdata),
    .dm_rdata(dmRdata), .dm_done(dmDone), .dm_err(dmErr), .dm_stall(dmStall),
    .mem_en(memEn), .mem_wr(memWr), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata)
  );

  mem_port_arbiter #(.LATENCY(1), .AW(16), .DW(16)) u_lat1 (
    .clk(clk), .rst(rst),
    .if_req(1'b0), .if_addr(16'h0000), .if_flush(1'b0),
    .if_rdata(l1IfRdata), .if_done(l1IfDone), .if_stall(l1IfStall),
    .dm_rd(l1Rd), .dm_wr(1'b0), .dm_addr(l1Addr), .dm_wdata(16'h0000),
    .dm_rdata(l1DmRdata), .dm_done(l1DmDone), .dm_err(l1DmErr), .dm_stall(l1DmStall),
    .mem_en(l1MemEn), .mem_wr(l1MemWr), .mem_addr(l1MemAddr), .mem_wdata(l1MemWdata),
    .mem_rdata(l1Mrd)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic fReq, input logic [15:0] fAddr,
                               input logic dRd, input logic dWr,
                               input logic [15:0] dAddr, input logic [15:0] dWd);
    ifReq   = fReq;
    ifAddr  = fAddr;
    dmRd    = dRd;
    dmWr    = dWr;
    dmAddr  = dAddr;
    dmWdata = dWd;
  endtask

  // Inputs change 1 unit after the rising edge; a "cycle" starts there.
  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Compare process: on every falling edge predict all outputs from the
  // model and the current inputs, compare, then advance the model by the
  // decision the upcoming rising edge will take.
  initial begin
    logic        eEn, eWr, eDmDone, eDmErr, eIfDone, eDmStall, eIfStall;
    logic [15:0] eAddr, eWd, eDmRdata, eIfRdata;
    forever begin
      @(negedge clk);
      eEn = 0; eWr = 0; eAddr = '0; eWd = '0;
      eDmDone = 0; eDmErr = 0; eDmRdata = '0; eIfDone = 0; eIfRdata = '0;
      if (rst) begin
        if (mOwner == OWN_ERR) begin
          eDmDone = 1; eDmErr = 1;
        end else if (mOwner != OWN_NONE) begin
          eEn = 1; eWr = mWr; eAddr = mAddr; eWd = mWdata;
          if (mAge == LAT) begin
            if (mOwner == OWN_D) begin
              eDmDone  = 1;
              eDmRdata = mWr ? 16'h0000 : memRdata;
            end else if (!mKill && !ifFlush) begin
              eIfDone  = 1;
              eIfRdata = memRdata;
            end
          end
        end
      end
      eDmStall = (dmRd | dmWr) & ~eDmDone;
      eIfStall = ifReq & ~eIfDone & ~ifFlush;

      checkOutput("model mem_en", memEn, eEn);
      checkOutput("model mem_wr", memWr, eWr);
      checkOutput("model mem_addr", memAddr, eAddr);
      if (eWr) checkOutput("model mem_wdata", memWdata, eWd);
      checkOutput("model dm_done", dmDone, eDmDone);
      checkOutput("model dm_err", dmErr, eDmErr);
      checkOutput("model dm_rdata", dmRdata, eDmRdata);
      checkOutput("model if_done", ifDone, eIfDone);
      checkOutput("model if_rdata", ifRdata, eIfRdata);
      checkOutput("model dm_stall", dmStall, eDmStall);
      checkOutput("model if_stall", ifStall, eIfStall);

      if (!rst) begin
        mOwner = OWN_NONE; mAge = 0; mAddr = '0; mWdata = '0; mWr = 0; mKill = 0;
      end else if (mOwner == OWN_NONE) begin
        if (dmRd | dmWr) begin
          if (dmAddr[0]) begin
            mOwner = OWN_ERR;
          end else begin
            mOwner = OWN_D; mAge = 1; mAddr = dmAddr; mWdata = dmWdata; mWr = dmWr;
          end
        end else if (ifReq && !ifFlush) begin
          mOwner = OWN_I; mAge = 1; mAddr = ifAddr; mWr = 0;
        end
      end else if (mOwner == OWN_ERR) begin
        mOwner = OWN_NONE;
      end else if (mAge == LAT) begin
        mOwner = OWN_NONE; mKill = 0;
      end else begin
        if (mOwner == OWN_I && ifFlush) mKill = 1;
        mAge++;
      end
    end
  end

  // Directed sequences with hand-computed expectations, then randomized
  // requesters checked by the model, then the summary.
  initial begin
    logic sawDm, sawIf;
    int   kind;
    rst = 1'b0; ifFlush = 1'b0; memRdata = '0; l1Rd = 1'b0; l1Addr = '0; l1Mrd = '0;
    applyStimulus(0, 16'h0, 0, 0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    nextCycle;

    // Single fetch: access held cycles 1-4, done in cycle 4.
    $display("[TB] single fetch");
    memRdata = 16'hBEEF;
    applyStimulus(1, 16'h0010, 0, 0, 16'h0, 16'h0);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      checkOutput("fetch mem_en", memEn, (c >= 1 && c <= 4));
      checkOutput("fetch mem_addr", memAddr, (c >= 1 && c <= 4) ? 16'h0010 : 16'h0000);
      checkOutput("fetch if_done", ifDone, (c == 4));
      checkOutput("fetch if_rdata", ifRdata, (c == 4) ? 16'hBEEF : 16'h0000);
      checkOutput("fetch if_stall", ifStall, (c <= 3));
      nextCycle;
      if (c == 4) ifReq = 1'b0;
    end

    // Write and fetch together: write first, fetch granted in cycle 5.
    $display("[TB] write beats fetch");
    memRdata = 16'hCAFE;
    applyStimulus(1, 16'h0050, 0, 1, 16'h0020, 16'h1234);
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      checkOutput("prio mem_en", memEn, (c >= 1 && c <= 4) || (c >= 6 && c <= 9));
      checkOutput("prio mem_wr", memWr, (c >= 1 && c <= 4));
      checkOutput("prio mem_addr", memAddr, (c >= 1 && c <= 4) ? 16'h0020 :
                                            (c >= 6 && c <= 9) ? 16'h0050 : 16'h0000);
      if (c >= 1 && c <= 4) checkOutput("prio mem_wdata", memWdata, 16'h1234);
      checkOutput("prio dm_done", dmDone, (c == 4));
      checkOutput("prio dm_rdata", dmRdata, 16'h0000);
      checkOutput("prio dm_stall", dmStall, (c <= 3));
      checkOutput("prio if_done", ifDone, (c == 9));
      checkOutput("prio if_rdata", ifRdata, (c == 9) ? 16'hCAFE : 16'h0000);
      nextCycle;
      if (c == 1) begin
        dmAddr  = 16'h0023;
        dmWdata = 16'hFFFF;
      end
      if (c == 4) dmWr = 1'b0;
      if (c == 9) ifReq = 1'b0;
    end

    // Misaligned read: error pulse next cycle, no memory access.
    $display("[TB] misaligned read");
    applyStimulus(0, 16'h0, 1, 0, 16'h0021, 16'h0);
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      checkOutput("err dm_done", dmDone, (c == 1));
      checkOutput("err dm_err", dmErr, (c == 1));
      checkOutput("err mem_en", memEn, 1'b0);
      checkOutput("err dm_stall", dmStall, (c == 0));
      nextCycle;
      if (c == 1) dmRd = 1'b0;
    end

    // Flushed fetch: memory still busy 4 cycles, no done pulse.
    $display("[TB] flushed fetch");
    applyStimulus(1, 16'h0040, 0, 0, 16'h0, 16'h0);
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      checkOutput("flush mem_en", memEn, (c >= 1 && c <= 4));
      checkOutput("flush if_done", ifDone, 1'b0);
      checkOutput("flush if_stall", ifStall, (c <= 1));
      nextCycle;
      if (c == 1) begin
        ifFlush = 1'b1;
        ifReq   = 1'b0;
      end
      if (c == 2) ifFlush = 1'b0;
    end

    // Reset in the middle of a write; request is re-granted afterwards.
    $display("[TB] reset during write");
    applyStimulus(0, 16'h0, 0, 1, 16'h0030, 16'h5555);
    for (int c = 0; c <= 9; c++) begin
      if (c == 2) begin
        #2 rst = 1'b0;
        #1;
        checkOutput("rst async mem_en", memEn, 1'b0);
        checkOutput("rst async mem_wr", memWr, 1'b0);
        checkOutput("rst async dm_done", dmDone, 1'b0);
      end
      @(negedge clk);
      checkOutput("rst mem_en", memEn, (c == 1) || (c >= 5 && c <= 8));
      checkOutput("rst mem_wr", memWr, (c == 1) || (c >= 5 && c <= 8));
      if (c == 1 || (c >= 5 && c <= 8)) checkOutput("rst mem_wdata", memWdata, 16'h5555);
      checkOutput("rst dm_done", dmDone, (c == 8));
      nextCycle;
      if (c == 3) rst = 1'b1;
      if (c == 8) dmWr = 1'b0;
    end

    // LATENCY=1 instance: back-to-back reads complete every 2nd cycle.
    $display("[TB] latency-1 reads");
    l1Rd = 1'b1; l1Addr = 16'h0002;
    for (int c = 0; c <= 4; c++) begin
      l1Mrd = 16'hA000 + 16'(c);
      @(negedge clk);
      checkOutput("lat1 dm_done", l1DmDone, (c == 1) || (c == 3));
      checkOutput("lat1 dm_rdata", l1DmRdata, (c == 1) ? 16'hA001 : (c == 3) ? 16'hA003 : 16'h0000);
      checkOutput("lat1 mem_en", l1MemEn, (c == 1) || (c == 3));
      checkOutput("lat1 mem_addr", l1MemAddr, (c == 1) ? 16'h0002 : (c == 3) ? 16'h0004 : 16'h0000);
      checkOutput("lat1 dm_stall", l1DmStall, (c == 0) || (c == 2));
      checkOutput("lat1 quiet", {l1IfDone, l1IfStall, l1DmErr, l1MemWr}, 4'b0000);
      checkOutput("lat1 quiet data", l1IfRdata | l1MemWdata, 16'h0000);
      nextCycle;
      if (c == 1) l1Addr = 16'h0004;
      if (c == 3) l1Rd = 1'b0;
    end

    // Randomized requesters; done pulses observed from the DUT only steer
    // the stimulus, the model supplies every expectation.
    $display("[TB] random traffic");
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      sawDm = dmDone;
      sawIf = ifDone;
      nextCycle;
      if (!rst) rst = 1'b1;
      memRdata = 16'($urandom);
      ifFlush  = 1'b0;
      if (dmRd | dmWr) begin
        if (sawDm) begin
          dmRd = 1'b0; dmWr = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          dmWdata = 16'($urandom);
        end
      end else if ($urandom_range(0, 3) == 0) begin
        kind    = int'($urandom_range(0, 2));
        dmRd    = (kind != 1);
        dmWr    = (kind != 0);
        dmAddr  = ($urandom_range(0, 7) == 0) ? (16'($urandom) | 16'h0001)
                                              : (16'($urandom) & 16'hFFFE);
        dmWdata = 16'($urandom);
      end
      if (ifReq) begin
        if (sawIf) begin
          ifReq  = 1'($urandom_range(0, 1));
          ifAddr = 16'($urandom) & 16'hFFFE;
        end else if ($urandom_range(0, 15) == 0) begin
          ifFlush = 1'b1;
          ifAddr  = 16'($urandom) & 16'hFFFE;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        ifReq  = 1'b1;
        ifAddr = 16'($urandom) & 16'hFFFE;
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b0;
      end
    end

    rst = 1'b1;
    applyStimulus(0, 16'h0, 0, 0, 16'h0, 16'h0);
    ifFlush = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
